// File: rtl/fu_pkg.sv
// rtl/fu_pkg.sv - opcode constants and scheduler state type for the shared FU
package fu_pkg;

    localparam logic [4:0] FU_ADD    = 5'd0;
    localparam logic [4:0] FU_SUB    = 5'd1;
    localparam logic [4:0] FU_MULT   = 5'd2;
    localparam logic [4:0] FU_SLL    = 5'd3;
    localparam logic [4:0] FU_SRL    = 5'd4;
    localparam logic [4:0] FU_AND    = 5'd5;
    localparam logic [4:0] FU_OR     = 5'd6;
    localparam logic [4:0] FU_NOT    = 5'd7;
    localparam logic [4:0] FU_XOR    = 5'd8;
    localparam logic [4:0] FU_OP_MAX = 5'd8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } fu_state_e;

endpackage

// File: rtl/fu_sched_alu.sv
// rtl/fu_sched_alu.sv - shared combinational FU datapath fed from latched operands
import fu_pkg::*;

module fu_sched_alu #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 5
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] result
);

    // Shifts use the whole of b: a shift count >= DATA_W yields zero.
    // Opcodes beyond FU_OP_MAX fall into the default and produce zero.
    always_comb begin
        result = '0;
        case (op)
            OP_W'(FU_ADD):  result = a + b;
            OP_W'(FU_SUB):  result = a - b;
            OP_W'(FU_MULT): result = a * b;
            OP_W'(FU_SLL):  result = a << b;
            OP_W'(FU_SRL):  result = a >> b;
            OP_W'(FU_AND):  result = a & b;
            OP_W'(FU_OR):   result = a | b;
            OP_W'(FU_NOT):  result = ~a;
            OP_W'(FU_XOR):  result = a ^ b;
            default:        result = '0;
        endcase
    end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, search starts at rr_ptr
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant
);

    // Walk upward from rr_ptr with wrap; first asserted request wins.
    always_comb begin
        logic found;
        int   pos;
        grant = '0;
        found = 1'b0;
        pos   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pos = int'(rr_ptr) + i;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            if (!found && req[pos[PTR_W-1:0]]) begin
                grant[pos[PTR_W-1:0]] = 1'b1;
                found                 = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fu_sched.sv
// rtl/fu_sched.sv - round-robin scheduler sharing one FU between requesters (option: FU_SCHED_ILLEGAL_CHK_EN)
import fu_pkg::*;

module fu_sched #(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = 32,
    parameter int OP_W     = 5,
    parameter int MULT_LAT = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ*OP_W-1:0]   req_op,
    output logic [NUM_REQ-1:0]        rsp_valid,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_err,
    output logic                      busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

    fu_state_e          state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   owner;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  a_q;
    logic [DATA_W-1:0]  b_q;
    logic [OP_W-1:0]    op_q;

    logic [NUM_REQ-1:0] grant;
    logic [PTR_W-1:0]   grant_idx;
    logic [PTR_W-1:0]   ptr_next;
    logic [DATA_W-1:0]  a_sel;
    logic [DATA_W-1:0]  b_sel;
    logic [OP_W-1:0]    op_sel;
    logic [DATA_W-1:0]  alu_result;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .req    (req_valid),
        .rr_ptr (rr_ptr),
        .grant  (grant)
    );

    fu_sched_alu #(
        .DATA_W (DATA_W),
        .OP_W   (OP_W)
    ) u_alu (
        .a      (a_q),
        .b      (b_q),
        .op     (op_q),
        .result (alu_result)
    );

    // Grant is only exposed while idle; the winner is accepted on this edge.
    assign req_ready = (state == IDLE) ? grant : '0;

    // Encode the one-hot grant and pick the winner's operand slices.
    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grant_idx = PTR_W'(i);
            end
        end
    end

    assign a_sel    = req_a[grant_idx*DATA_W +: DATA_W];
    assign b_sel    = req_b[grant_idx*DATA_W +: DATA_W];
    assign op_sel   = req_op[grant_idx*OP_W +: OP_W];
    assign ptr_next = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

`ifdef FU_SCHED_ILLEGAL_CHK_EN
    logic op_illegal;
    assign op_illegal = (op_q > OP_W'(FU_OP_MAX));
`else
    assign rsp_err = 1'b0;
`endif

    // Scheduler FSM: accept in IDLE, count down MULT in EXEC, hold the response in RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            cnt       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            busy      <= 1'b0;
`ifdef FU_SCHED_ILLEGAL_CHK_EN
            rsp_err   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|grant) begin
                        a_q    <= a_sel;
                        b_q    <= b_sel;
                        op_q   <= op_sel;
                        owner  <= grant_idx;
                        rr_ptr <= ptr_next;
                        cnt    <= (op_sel == OP_W'(FU_MULT)) ? CNT_W'(MULT_LAT - 1) : '0;
                        busy   <= 1'b1;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        rsp_data  <= alu_result;
                        rsp_valid <= NUM_REQ'(1) << owner;
`ifdef FU_SCHED_ILLEGAL_CHK_EN
                        rsp_err   <= op_illegal;
`endif
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready[owner]) begin
                        rsp_valid <= '0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
